// File: rtl/width_change_gearbox.sv
// Width converter: packs/unpacks AWIDTH-bit words into BWIDTH-bit words MSB-first with valid/ready on both sides.
// Optional residual flush with b_last marker is enabled by defining WIDTH_CHANGE_FLUSH_EN.
module width_change_gearbox #(
    parameter int AWIDTH = 8,
    parameter int BWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_vld,
    output logic              a_rdy,
    input  logic [AWIDTH-1:0] a,
    output logic              b_vld,
    input  logic              b_rdy,
    output logic [BWIDTH-1:0] b
`ifdef WIDTH_CHANGE_FLUSH_EN
    ,
    input  logic              flush,
    output logic              b_last
`endif
);

    localparam int BUFW = AWIDTH + BWIDTH;
    localparam int CW   = $clog2(BUFW + 1);
    localparam logic [CW-1:0] BW_C = CW'(BWIDTH);
    localparam logic [CW-1:0] AW_C = CW'(AWIDTH);

    logic [BUFW-1:0] buf_q, buf_d, buf_pop, a_ext;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_pop;
    logic            push, pop;
    logic            flush_pend;

    assign a_rdy = (cnt_q <= BW_C) && !flush_pend;
    // A pending flush lets a short residual out as a zero-padded word.
    assign b_vld = (cnt_q >= BW_C) || (flush_pend && (cnt_q != '0));
    assign b     = buf_q[BUFW-1 -: BWIDTH];

    assign push  = a_vld && a_rdy;
    assign pop   = b_vld && b_rdy;
    assign a_ext = {a, {BWIDTH{1'b0}}};

    always_comb begin
        buf_pop = buf_q;
        cnt_pop = cnt_q;
        if (pop) begin
            buf_pop = buf_q << BWIDTH;
            cnt_pop = (cnt_q >= BW_C) ? (cnt_q - BW_C) : '0;
        end
        buf_d = buf_pop;
        cnt_d = cnt_pop;
        // Bits below cnt are always zero, so OR-ing the shifted word appends it.
        if (push) begin
            buf_d = buf_pop | (a_ext >> cnt_pop);
            cnt_d = cnt_pop + AW_C;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef WIDTH_CHANGE_FLUSH_EN
    // Pending survives only while bits remain; the final pop or an empty buffer ends it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend <= 1'b0;
        end else begin
            flush_pend <= (flush_pend || flush) && (cnt_d != '0);
        end
    end

    assign b_last = flush_pend && (cnt_q != '0) && (cnt_q <= BW_C);
`else
    assign flush_pend = 1'b0;
`endif

endmodule

// File: tb/tb_width_change_gearbox.sv
// Self-checking bench for width_change_gearbox: vector table, directed sequences and a bit-queue reference model.
module tb_width_change_gearbox;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_vld = 1'b0, b_rdy = 1'b0;
    logic [7:0]  a = '0;
    logic        a_rdy, b_vld;
    logic [11:0] b;
    logic        a2_vld = 1'b0, b2_rdy = 1'b1;
    logic [11:0] a2 = '0;
    logic        a2_rdy, b2_vld;
    logic [7:0]  b2;
`ifdef WIDTH_CHANGE_FLUSH_EN
    logic        flush = 1'b0, flush2 = 1'b0;
    logic        b_last, b2_last;
`endif

    always #5 clk = ~clk;

    width_change_gearbox #(.AWIDTH(8), .BWIDTH(12)) dut (
        .clk(clk), .rst_n(rst_n), .a_vld(a_vld), .a_rdy(a_rdy), .a(a),
        .b_vld(b_vld), .b_rdy(b_rdy), .b(b)
`ifdef WIDTH_CHANGE_FLUSH_EN
        , .flush(flush), .b_last(b_last)
`endif
    );

    width_change_gearbox #(.AWIDTH(12), .BWIDTH(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .a_vld(a2_vld), .a_rdy(a2_rdy), .a(a2),
        .b_vld(b2_vld), .b_rdy(b2_rdy), .b(b2)
`ifdef WIDTH_CHANGE_FLUSH_EN
        , .flush(flush2), .b_last(b2_last)
`endif
    );

    typedef struct {
        logic        a_vld;
        logic [7:0]  a;
        logic        b_rdy;
        logic        e_ardy;
        logic        e_bvld;
        logic [11:0] e_b;
    } vec_t;

    vec_t        tbl[8];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  in_words[$];
    logic [11:0] got[$];
    logic [11:0] exp_words[$];
    bit          mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Feeds in_words through dut with b_rdy=1, collecting every output word into got.
    task automatic run_seq(input bit gaps);
        int idx = 0, wait_c = 0, cyc = 0, tail = 0;
        got.delete();
        b_rdy = 1'b1;
        while (tail < 4) begin
            @(negedge clk);
            cyc++;
            if (cyc > 300) begin
                errors++;
                checks++;
                $display("FAIL seq_timeout: got %0d words pushed expected %0d", idx, in_words.size());
                a_vld = 1'b0;
                break;
            end
            if (b_vld && b_rdy) got.push_back(b);
            if (idx < in_words.size()) begin
                if (wait_c > 0) begin
                    a_vld = 1'b0;
                    wait_c--;
                end else begin
                    a_vld = 1'b1;
                    a = in_words[idx];
                    if (a_rdy) begin
                        idx++;
                        wait_c = gaps ? 1 + (idx % 3) : 0;
                    end
                end
            end else begin
                a_vld = 1'b0;
                tail++;
            end
        end
    endtask

    task automatic cmp_seq(input string name);
        chk({name, "_len"}, got.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < got.size(); i++)
            chk({name, "_word"}, {20'h0, got[i]}, {20'h0, exp_words[i]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_vld = 1'b0;
        a2_vld = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[1] = '{1'b1, 8'haa, 1'b0, 1'b1, 1'b0, 12'h550};
        tbl[2] = '{1'b1, 8'hbb, 1'b0, 1'b0, 1'b1, 12'h55a};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 12'h55a};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 12'h55a};
        tbl[5] = '{1'b1, 8'hbb, 1'b0, 1'b1, 1'b0, 12'ha00};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 12'habb};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 12'h000};

        #8;
        chk("rst_a_rdy", a_rdy, 1);
        chk("rst_b_vld", b_vld, 0);
        chk("rst_b", b, 0);
        chk("rst2_a_rdy", a2_rdy, 1);
        chk("rst2_b_vld", b2_vld, 0);
        #4 rst_n = 1'b1;

        // Backpressure table
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_vld = tbl[i].a_vld;
            a     = tbl[i].a;
            b_rdy = tbl[i].b_rdy;
            chk("tbl_a_rdy", a_rdy, tbl[i].e_ardy);
            chk("tbl_b_vld", b_vld, tbl[i].e_bvld);
            chk("tbl_b", b, tbl[i].e_b);
        end

        in_words = '{8'h55, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee};
        exp_words = '{12'h55a, 12'habb, 12'hccd, 12'hdee};
        run_seq(1'b0);
        cmp_seq("stream");
        run_seq(1'b1);
        cmp_seq("gaps");

        // Asynchronous reset between edges with a full word pending
        b_rdy = 1'b0;
        @(negedge clk); a_vld = 1'b1; a = 8'h55;
        @(negedge clk); a_vld = 1'b1; a = 8'haa;
        @(negedge clk); a_vld = 1'b0;
        chk("pre_rst_b", b, 12'h55a);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_b_vld", b_vld, 0);
        chk("mid_rst_a_rdy", a_rdy, 1);
        chk("mid_rst_b", b, 0);
        #1 rst_n = 1'b1;
        in_words = '{8'hbb, 8'hcc, 8'hdd};
        exp_words = '{12'hbbc, 12'hcdd};
        run_seq(1'b0);
        cmp_seq("post_rst");

        // 12-to-8 down-sizing
        b2_rdy = 1'b1;
        @(negedge clk); chk("d_a_rdy0", a2_rdy, 1); chk("d_b_vld0", b2_vld, 0);
        a2_vld = 1'b1; a2 = 12'habc;
        @(negedge clk); chk("d_a_rdy1", a2_rdy, 0); chk("d_b_vld1", b2_vld, 1); chk("d_b1", b2, 8'hab);
        a2 = 12'hdef;
        @(negedge clk); chk("d_a_rdy2", a2_rdy, 1); chk("d_b_vld2", b2_vld, 0);
        @(negedge clk); a2_vld = 1'b0;
        chk("d_a_rdy3", a2_rdy, 0); chk("d_b_vld3", b2_vld, 1); chk("d_b3", b2, 8'hcd);
        @(negedge clk); chk("d_a_rdy4", a2_rdy, 1); chk("d_b_vld4", b2_vld, 1); chk("d_b4", b2, 8'hef);
        @(negedge clk); chk("d_a_rdy5", a2_rdy, 1); chk("d_b_vld5", b2_vld, 0);

`ifdef WIDTH_CHANGE_FLUSH_EN
        do_reset();
        b_rdy = 1'b1;
        @(negedge clk); a_vld = 1'b1; a = 8'h55;
        @(negedge clk); a_vld = 1'b0; flush = 1'b1;
        chk("f_b_vld_pre", b_vld, 0);
        @(negedge clk); flush = 1'b0;
        chk("f_b_vld", b_vld, 1); chk("f_b", b, 12'h550); chk("f_last", b_last, 1); chk("f_a_rdy", a_rdy, 0);
        @(negedge clk);
        chk("f_b_vld_post", b_vld, 0); chk("f_a_rdy_post", a_rdy, 1); chk("f_last_post", b_last, 0);
        in_words = '{8'h55, 8'haa, 8'hbb, 8'hcc};
        exp_words = '{12'h55a, 12'habb};
        run_seq(1'b0);
        cmp_seq("f_stream");
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("f2_b_vld", b_vld, 1); chk("f2_b", b, 12'hcc0); chk("f2_last", b_last, 1);
        @(negedge clk);
        chk("f2_b_vld_post", b_vld, 0); chk("f2_a_rdy_post", a_rdy, 1);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("f0_b_vld", b_vld, 0); chk("f0_last", b_last, 0);
        @(negedge clk);
        chk("f0_a_rdy", a_rdy, 1);
`endif

        // Random traffic against a bit-queue model
        do_reset();
        mq.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        e_ardy, e_bvld;
            logic [11:0] e_b;
            int          bias;
            @(negedge clk);
            e_ardy = (mq.size() <= 12);
            e_bvld = (mq.size() >= 12);
            e_b = '0;
            for (int i = 0; i < 12; i++)
                if (i < mq.size()) e_b[11-i] = mq[i];
            chk("rnd_a_rdy", a_rdy, e_ardy);
            chk("rnd_b_vld", b_vld, e_bvld);
            chk("rnd_b", b, e_b);
            bias  = (cyc / 500) % 3;
            a_vld = ($urandom_range(0, 3) > bias);
            a     = 8'($urandom);
            b_rdy = ($urandom_range(0, 3) >= bias);
            if (b_rdy && e_bvld)
                for (int i = 0; i < 12; i++) void'(mq.pop_front());
            if (a_vld && e_ardy)
                for (int i = 7; i >= 0; i--) mq.push_back(a[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
